mmix_mem_bridge: RTL and testbench

Synthesizable responder for the CPU's `mmix_*` memory bus, mapping each byte/wyde/tetra/octa request onto a 32-bit Avalon-MM master port (on-chip RAM or the SDRAM controller). It sits between `cpu` and the system interconnect and replaces the simulation memory model on hardware. It performs MMIX big-endian lane placement, splits octabytes into two tetra beats and returns one `mmix_done` pulse per request.

---
 rtl/mmix_mem_bridge_if.sv | 42 ++++
 rtl/mmix_mem_bridge.sv | 200 ++++++++++++++++++++
 tb/tb_mmix_mem_bridge.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mmix_mem_bridge_if.sv
// Bus bundles for mmix_mem_bridge: the CPU-side mmix_* request bus and the
// 32-bit Avalon-MM port toward on-chip RAM / SDRAM.
interface mmix_bus_if;
    logic [63:0] mmix_address;
    logic [1:0]  mmix_datasize;
    logic        mmix_read;
    logic        mmix_write;
    logic [63:0] mmix_writedata;
    logic [63:0] mmix_readdata;
    logic        mmix_done;
    logic        bus_err;

    modport master (
        output mmix_address, mmix_datasize, mmix_read, mmix_write, mmix_writedata,
        input  mmix_readdata, mmix_done, bus_err
    );
    modport slave (
        input  mmix_address, mmix_datasize, mmix_read, mmix_write, mmix_writedata,
        output mmix_readdata, mmix_done, bus_err
    );
endinterface

interface avm_bus_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [3:0]        avm_byteenable;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata;
    logic              avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );
    modport slave (
        input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/mmix_mem_bridge.sv
// MMIX memory bus responder onto a 32-bit big-endian Avalon-MM master; octas split in two beats.
// Define MMIX_BRIDGE_TIMEOUT_EN to enable the waitrequest watchdog (abort with bus_err).
module mmix_mem_bridge #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic      clk,
    input  logic      reset_n,
    mmix_bus_if.slave mmix,
    avm_bus_if.master avm
);
    typedef enum logic [2:0] {S_IDLE, S_BEAT_HI, S_BEAT_LO, S_DONE, S_GAP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       wlo_q, wlo_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        boff_q, boff_d;
    logic [31:0]       hi_q, hi_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              is_rd_q, is_rd_d;
    logic              timeout;

    logic [1:0]        req_b;
    logic [3:0]        req_be;
    logic [31:0]       req_wd;
    logic [31:0]       rd_shift;
    logic [63:0]       rd_lane;
    logic              unused_addr_hi;

    assign req_b          = mmix.mmix_address[1:0];
    assign unused_addr_hi = ^mmix.mmix_address[63:ADDR_W];

    // Big-endian lane placement: byte offset b lives in bits [31-8b -: 8].
    always_comb begin
        req_be = 4'b1111;
        req_wd = mmix.mmix_writedata[31:0];
        case (mmix.mmix_datasize)
            2'd0: begin
                req_be = 4'b1000 >> req_b;
                req_wd = {24'd0, mmix.mmix_writedata[7:0]} << {2'd3 - req_b, 3'b000};
            end
            2'd1: begin
                req_be = req_b[1] ? 4'b0011 : 4'b1100;
                req_wd = {16'd0, mmix.mmix_writedata[15:0]} << {~req_b[1], 4'b0000};
            end
            2'd3:    req_wd = mmix.mmix_writedata[63:32];
            default: ;
        endcase
    end

    always_comb begin
        rd_shift = avm.avm_readdata;
        rd_lane  = {32'd0, avm.avm_readdata};
        case (size_q)
            2'd0: begin
                rd_shift = avm.avm_readdata >> {2'd3 - boff_q, 3'b000};
                rd_lane  = {56'd0, rd_shift[7:0]};
            end
            2'd1: begin
                rd_shift = avm.avm_readdata >> {~boff_q[1], 4'b0000};
                rd_lane  = {48'd0, rd_shift[15:0]};
            end
            default: ;
        endcase
    end

`ifdef MMIX_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign timeout = avm.avm_waitrequest && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if ((state_q == S_BEAT_HI || state_q == S_BEAT_LO) && avm.avm_waitrequest)
            cnt_d = cnt_q + 1'b1;
        err_d = err_q;
        if (state_q == S_IDLE)
            err_d = 1'b0;
        else if (timeout && (state_q == S_BEAT_HI || state_q == S_BEAT_LO))
            err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign mmix.bus_err = (state_q == S_DONE) && err_q;
`else
    assign timeout      = 1'b0;
    assign mmix.bus_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        wlo_d   = wlo_q;
        size_d  = size_q;
        boff_d  = boff_q;
        hi_d    = hi_q;
        rdata_d = rdata_q;
        is_rd_d = is_rd_q;
        case (state_q)
            S_IDLE: begin
                if (mmix.mmix_read || mmix.mmix_write) begin
                    state_d = S_BEAT_HI;
                    rd_d    = mmix.mmix_read;
                    wr_d    = !mmix.mmix_read;
                    is_rd_d = mmix.mmix_read;
                    addr_d  = {mmix.mmix_address[ADDR_W-1:3],
                               mmix.mmix_datasize == 2'd3 ? 1'b0 : mmix.mmix_address[2], 2'b00};
                    be_d    = req_be;
                    wdata_d = req_wd;
                    wlo_d   = mmix.mmix_writedata[31:0];
                    size_d  = mmix.mmix_datasize;
                    boff_d  = req_b;
                end
            end
            S_BEAT_HI, S_BEAT_LO: begin
                if (timeout) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = S_DONE;
                    if (is_rd_q)
                        rdata_d = 64'hFFFF_FFFF_FFFF_FFFF;
                end else if (!avm.avm_waitrequest) begin
                    if (state_q == S_BEAT_HI && size_q == 2'd3) begin
                        hi_d    = avm.avm_readdata;
                        addr_d  = addr_q + ADDR_W'(4);
                        wdata_d = wlo_q;
                        state_d = S_BEAT_LO;
                    end else begin
                        rd_d    = 1'b0;
                        wr_d    = 1'b0;
                        state_d = S_DONE;
                        if (is_rd_q)
                            rdata_d = (state_q == S_BEAT_LO) ? {hi_q, avm.avm_readdata} : rd_lane;
                    end
                end
            end
            // One dead cycle so a request level still held after done is not re-accepted.
            S_DONE:  state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            wlo_q   <= '0;
            size_q  <= '0;
            boff_q  <= '0;
            hi_q    <= '0;
            rdata_q <= '0;
            is_rd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            wlo_q   <= wlo_d;
            size_q  <= size_d;
            boff_q  <= boff_d;
            hi_q    <= hi_d;
            rdata_q <= rdata_d;
            is_rd_q <= is_rd_d;
        end
    end

    assign avm.avm_address    = addr_q;
    assign avm.avm_read       = rd_q;
    assign avm.avm_write      = wr_q;
    assign avm.avm_byteenable = be_q;
    assign avm.avm_writedata  = wdata_q;
    assign mmix.mmix_readdata = rdata_q;
    assign mmix.mmix_done     = (state_q == S_DONE);
endmodule

// File: tb/tb_mmix_mem_bridge.sv
// Directed bench for mmix_mem_bridge with a small Avalon word-memory model.
module tb_mmix_mem_bridge;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mmix_bus_if mif();
    avm_bus_if #(.ADDR_W(32)) aif();

    mmix_mem_bridge #(.ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .mmix(mif.slave),
        .avm(aif.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model
    logic [31:0] mem [0:255];
    logic        mem_ready = 1'b0;
    int          stall_n = 0;
    logic        stuck = 1'b0;
    int          stalls_done;
    int          txn_cnt;
    int          done_cnt;
    logic [31:0] last_addr, prev_addr, last_wd;
    logic [3:0]  last_be;
    logic        cmd;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    assign cmd = aif.avm_read | aif.avm_write;
    assign aif.avm_waitrequest = stuck | (cmd && (stalls_done < stall_n));
    assign aif.avm_readdata    = mem[aif.avm_address[9:2]];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h40] <= 32'h1122_3344;
            mem[8'h81] <= 32'hAABB_CCDD;
            mem[8'hC2] <= 32'hDEAD_BEEF;
            mem[8'hC3] <= 32'h0123_4567;
            mem_ready   <= 1'b1;
            stalls_done <= 0;
            txn_cnt     <= 0;
            done_cnt    <= 0;
            last_addr   <= '0;
            prev_addr   <= '0;
            last_wd     <= '0;
            last_be     <= '0;
        end else begin
            if (!cmd) stalls_done <= 0;
            else if (aif.avm_waitrequest) stalls_done <= stalls_done + 1;
            if (cmd && !aif.avm_waitrequest) begin
                txn_cnt   <= txn_cnt + 1;
                prev_addr <= last_addr;
                last_addr <= aif.avm_address;
                if (aif.avm_write) begin
                    mem[aif.avm_address[9:2]] <= merge(mem[aif.avm_address[9:2]], aif.avm_writedata, aif.avm_byteenable);
                    last_be <= aif.avm_byteenable;
                    last_wd <= aif.avm_writedata;
                end
            end
            if (mif.mmix_done) done_cnt <= done_cnt + 1;
        end
    end

    // First-beat command snapshot taken one cycle after the request edge
    logic [31:0] cmd_addr, cmd_wd;
    logic [3:0]  cmd_be;
    logic        cmd_rd, done_err;
    int          lat;

    task automatic run_req(input logic is_rd, input logic [1:0] sz, input logic [63:0] addr,
                           input logic [63:0] wd, input int budget, input int hold, output int latency);
        latency = -1;
        mif.mmix_address   = addr;
        mif.mmix_datasize  = sz;
        mif.mmix_writedata = wd;
        mif.mmix_read      = is_rd;
        mif.mmix_write     = !is_rd;
        for (int c = 1; c <= budget && latency < 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) begin
                cmd_addr = aif.avm_address;
                cmd_be   = aif.avm_byteenable;
                cmd_wd   = aif.avm_writedata;
                cmd_rd   = aif.avm_read;
            end
            if (mif.mmix_done) begin
                latency  = c;
                done_err = mif.bus_err;
            end
        end
        repeat (hold) @(negedge clk);
        mif.mmix_read  = 1'b0;
        mif.mmix_write = 1'b0;
        $display("txn rd=%0d size=%0d addr=%h wd=%h lat=%0d readdata=%h", is_rd, sz, addr, wd, latency, mif.mmix_readdata);
        repeat (3) @(negedge clk);
    endtask

    int txn_base, done_base;

    initial begin
        mif.mmix_address   = '0;
        mif.mmix_datasize  = '0;
        mif.mmix_read      = 1'b0;
        mif.mmix_write     = 1'b0;
        mif.mmix_writedata = '0;
        repeat (4) @(negedge clk);
        check("rst_done", mif.mmix_done, 0);
        check("rst_readdata", mif.mmix_readdata, 0);
        check("rst_avm_read", aif.avm_read, 0);
        check("rst_avm_write", aif.avm_write, 0);
        check("rst_avm_be", aif.avm_byteenable, 0);
        check("rst_avm_wd", aif.avm_writedata, 0);
        check("rst_avm_addr", aif.avm_address, 0);
        check("rst_bus_err", mif.bus_err, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Byte read 0x103 from word 0x11223344
        run_req(1'b1, 2'd0, 64'h103, 64'h0, 20, 0, lat);
        check("b_rd_lat", lat, 2);
        check("b_rd_cmd", cmd_rd, 1);
        check("b_rd_addr", cmd_addr, 32'h100);
        check("b_rd_be", cmd_be, 4'b0001);
        check("b_rd_data", mif.mmix_readdata, 64'h44);

        // Wyde write 0xBEEF to 0x206
        done_base = done_cnt;
        run_req(1'b0, 2'd1, 64'h206, 64'hBEEF, 20, 0, lat);
        check("w_wr_lat", lat, 2);
        check("w_wr_addr", cmd_addr, 32'h204);
        check("w_wr_be", cmd_be, 4'b0011);
        check("w_wr_wd", cmd_wd, 32'h0000_BEEF);
        check("w_wr_model_wd", last_wd, 32'h0000_BEEF);
        check("w_wr_mem", mem[8'h81], 32'hAABB_BEEF);
        check("w_wr_dones", done_cnt - done_base, 1);
        check("w_wr_rd_kept", mif.mmix_readdata, 64'h44);

        // Octa read 0x30F with 3 stall cycles on the first beat
        stall_n = 3;
        run_req(1'b1, 2'd3, 64'h30F, 64'h0, 30, 0, lat);
        stall_n = 0;
        check("o_rd_lat", lat, 6);
        check("o_rd_addr0", prev_addr, 32'h308);
        check("o_rd_addr1", last_addr, 32'h30C);
        check("o_rd_data", mif.mmix_readdata, 64'hDEAD_BEEF_0123_4567);

        // Octa write then narrower reads of the same words
        run_req(1'b0, 2'd3, 64'h010, 64'h0102_0304_0506_0708, 20, 0, lat);
        check("o_wr_lat", lat, 3);
        check("o_wr_mem_hi", mem[8'h04], 32'h0102_0304);
        check("o_wr_mem_lo", mem[8'h05], 32'h0506_0708);
        check("o_wr_rd_kept", mif.mmix_readdata, 64'hDEAD_BEEF_0123_4567);
        run_req(1'b1, 2'd2, 64'h012, 64'h0, 20, 0, lat);
        check("t_rd_addr", cmd_addr, 32'h010);
        check("t_rd_be", cmd_be, 4'b1111);
        check("t_rd_data", mif.mmix_readdata, 64'h0102_0304);
        run_req(1'b1, 2'd0, 64'h015, 64'h0, 20, 0, lat);
        check("b1_rd_be", cmd_be, 4'b0100);
        check("b1_rd_data", mif.mmix_readdata, 64'h06);
        run_req(1'b1, 2'd1, 64'h016, 64'h0, 20, 0, lat);
        check("w_rd_be", cmd_be, 4'b0011);
        check("w_rd_data", mif.mmix_readdata, 64'h0708);
        run_req(1'b0, 2'd0, 64'h100, 64'hA5, 20, 0, lat);
        check("b0_wr_be", cmd_be, 4'b1000);
        check("b0_wr_wd", cmd_wd, 32'hA500_0000);

        // Read level held two cycles past done
        txn_base  = txn_cnt;
        done_base = done_cnt;
        run_req(1'b1, 2'd0, 64'h103, 64'h0, 20, 2, lat);
        check("hold_txns", txn_cnt - txn_base, 1);
        check("hold_dones", done_cnt - done_base, 1);

        // Reset during a stalled octa low beat
        mif.mmix_address  = 64'h308;
        mif.mmix_datasize = 2'd3;
        mif.mmix_read     = 1'b1;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        stuck     = 1'b1;
        done_base = done_cnt;
        repeat (2) @(negedge clk);
        check("rst_mid_stalled", aif.avm_read, 1);
        check("rst_mid_lo_addr", aif.avm_address, 32'h30C);
        reset_n       = 1'b0;
        mif.mmix_read = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rst_mid_read", aif.avm_read, 0);
        check("rst_mid_done", mif.mmix_done, 0);
        reset_n = 1'b1;
        stuck   = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_mid_no_done", done_cnt - done_base, 0);
        run_req(1'b1, 2'd0, 64'h102, 64'h0, 20, 0, lat);
        check("rst_mid_recover_lat", lat, 2);
        check("rst_mid_recover_data", mif.mmix_readdata, 64'h33);

        // Stuck waitrequest
        stuck = 1'b1;
`ifdef MMIX_BRIDGE_TIMEOUT_EN
        run_req(1'b1, 2'd0, 64'h103, 64'h0, 40, 0, lat);
        stuck = 1'b0;
        check("to_lat", lat, 9);
        check("to_bus_err", done_err, 1);
        check("to_readdata", mif.mmix_readdata, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        run_req(1'b1, 2'd0, 64'h103, 64'h0, 30, 0, lat);
        check("stuck_no_done", lat < 0, 1);
        check("stuck_cmd_held", aif.avm_read, 1);
        check("stuck_bus_err", mif.bus_err, 0);
        reset_n = 1'b0;
        stuck   = 1'b0;
        @(posedge clk); @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
